// File: rtl/pwl_act_pkg.sv
// Shared definitions for the piecewise-linear activation pipeline:
// mode encoding and width/constant helpers derived from the datapath parameters.
package pwl_act_pkg;

    typedef enum logic {
        MODE_TANH    = 1'b0,
        MODE_SIGMOID = 1'b1
    } mode_e;

    // Fixed-point 1.0 in the y format.
    function automatic int one_of(input int frac_w);
        return 1 << frac_w;
    endfunction

    // Largest positive value of a signed word of the given width.
    function automatic int pos_max_of(input int data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

    // Full width of the unsigned slope * |x| product.
    function automatic int prod_w_of(input int data_w, input int coef_w);
        return data_w + coef_w;
    endfunction

    // Width of the product after dropping the slope fraction bits.
    function automatic int rnd_w_of(input int data_w, input int coef_w, input int coef_frac);
        return data_w + coef_w - coef_frac;
    endfunction

endpackage

// File: rtl/pwl_coef_table.sv
// Slope/intercept register file: one write port, one combinational read port,
// cleared by reset so a fresh table always has to be loaded.
module pwl_coef_table
    import pwl_act_pkg::*;
#(
    parameter int SEG_LOG2 = 3,
    parameter int COEF_W   = 16,
    parameter int DATA_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [SEG_LOG2-1:0]        wr_addr,
    input  logic [COEF_W-1:0]          wr_slope,
    input  logic signed [DATA_W-1:0]   wr_icpt,
    input  logic [SEG_LOG2-1:0]        rd_addr,
    output logic [COEF_W-1:0]          rd_slope,
    output logic signed [DATA_W-1:0]   rd_icpt
);

    localparam int NSEG = 1 << SEG_LOG2;

    logic [COEF_W-1:0]        slope_q [NSEG];
    logic [COEF_W-1:0]        slope_d [NSEG];
    logic signed [DATA_W-1:0] icpt_q  [NSEG];
    logic signed [DATA_W-1:0] icpt_d  [NSEG];

    // Next table contents: hold everything, overwrite the addressed entry on a write.
    always_comb begin
        slope_d = slope_q;
        icpt_d  = icpt_q;
        if (we) begin
            slope_d[wr_addr] = wr_slope;
            icpt_d[wr_addr]  = wr_icpt;
        end
    end

    // Table storage; reset clears every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSEG; i++) begin
                slope_q[i] <= '0;
                icpt_q[i]  <= '0;
            end
        end else begin
            slope_q <= slope_d;
            icpt_q  <= icpt_d;
        end
    end

    // Reads see the pre-write contents during a write cycle.
    assign rd_slope = slope_q[rd_addr];
    assign rd_icpt  = icpt_q[rd_addr];

endmodule

// File: rtl/pwl_act_pipe.sv
// Three-stage piecewise-linear tanh/sigmoid unit with a loadable segment table
// and a single global stall driven by the output handshake.
module pwl_act_pipe
    import pwl_act_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 8,
    parameter int SEG_LOG2  = 3,
    parameter int SEG_SHIFT = 7,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  x_in,
    input  logic                      mode_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  y_out,
    input  logic                      cfg_we,
    input  logic [SEG_LOG2-1:0]       cfg_addr,
    input  logic [COEF_W-1:0]         cfg_slope,
    input  logic signed [DATA_W-1:0]  cfg_icpt
);

    localparam int STAGES    = 3;
    localparam int NSEG      = 1 << SEG_LOG2;
    localparam int PROD_W    = prod_w_of(DATA_W, COEF_W);
    localparam int RND_W     = rnd_w_of(DATA_W, COEF_W, COEF_FRAC);
    localparam int SUM_W     = RND_W + 2;
    localparam int ONE_I     = one_of(FRAC_W);
    localparam int POS_MAX_I = pos_max_of(DATA_W);

    localparam logic signed [DATA_W-1:0] ONE     = DATA_W'(ONE_I);
    localparam logic signed [DATA_W-1:0] POS_MAX = DATA_W'(POS_MAX_I);
    localparam logic signed [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Round half up while discarding the slope fraction bits.
    function automatic logic [RND_W-1:0] round_half_up(input logic [PROD_W-1:0] p);
        logic [PROD_W-1:0] t;
        t = p + PROD_W'(1 << (COEF_FRAC - 1));
        return RND_W'(t >> COEF_FRAC);
    endfunction

    // Clamp the intercept+product sum into the non-negative y range.
    function automatic logic signed [DATA_W-1:0] clamp_pos(input logic signed [SUM_W-1:0] s);
        if (s < 0)
            return '0;
        else if (s > $signed(SUM_W'(POS_MAX_I)))
            return POS_MAX;
        else
            return s[DATA_W-1:0];
    endfunction

    // Clamp a sigmoid reflection into [0, ONE].
    function automatic logic signed [DATA_W-1:0] clamp_unit(input logic signed [DATA_W:0] s);
        if (s < 0)
            return '0;
        else if (s > $signed((DATA_W+1)'(ONE_I)))
            return ONE;
        else
            return s[DATA_W-1:0];
    endfunction

    logic stall;
    logic adv;

    logic [DATA_W-1:0]   a_p0;
    logic [DATA_W-1:0]   idx_p0;
    logic                sat_p0;
    logic [COEF_W-1:0]   slope_p0;
    logic signed [DATA_W-1:0] icpt_p0;

    logic                vld_p1_q, vld_p1_d;
    logic [DATA_W-1:0]   a_p1_q, a_p1_d;
    logic                sgn_p1_q, sgn_p1_d;
    logic                sat_p1_q, sat_p1_d;
    mode_e               mode_p1_q, mode_p1_d;
    logic [COEF_W-1:0]   slope_p1_q, slope_p1_d;
    logic signed [DATA_W-1:0] icpt_p1_q, icpt_p1_d;

    logic                vld_p2_q, vld_p2_d;
    logic [RND_W-1:0]    pr_p2_q, pr_p2_d;
    logic                sgn_p2_q, sgn_p2_d;
    logic                sat_p2_q, sat_p2_d;
    mode_e               mode_p2_q, mode_p2_d;
    logic signed [DATA_W-1:0] icpt_p2_q, icpt_p2_d;

    logic                vld_p3_q, vld_p3_d;
    logic signed [DATA_W-1:0] y_p3_q, y_p3_d;

    logic [PROD_W-1:0]        prod_p1;
    logic signed [SUM_W-1:0]  sum_p2;
    logic signed [DATA_W-1:0] ypos_p2;
    logic signed [DATA_W-1:0] yfin_p2;

    // A held output freezes every stage; empty output slots never stall.
    assign stall     = vld_p3_q & ~out_ready;
    assign adv       = ~stall;
    assign in_ready  = ~stall;
    assign out_valid = vld_p3_q;
    assign y_out     = y_p3_q;

    pwl_coef_table #(
        .SEG_LOG2 (SEG_LOG2),
        .COEF_W   (COEF_W),
        .DATA_W   (DATA_W)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (cfg_we),
        .wr_addr  (cfg_addr),
        .wr_slope (cfg_slope),
        .wr_icpt  (cfg_icpt),
        .rd_addr  (idx_p0[SEG_LOG2-1:0]),
        .rd_slope (slope_p0),
        .rd_icpt  (icpt_p0)
    );

    // Stage 1 front end: magnitude, segment index and saturation flag.
    always_comb begin
        if (x_in == NEG_MIN)
            a_p0 = POS_MAX;
        else if (x_in[DATA_W-1])
            a_p0 = -x_in;
        else
            a_p0 = x_in;
        idx_p0 = a_p0 >> SEG_SHIFT;
        sat_p0 = (idx_p0 >= DATA_W'(NSEG));
    end

    // Next-state for all stages; every register holds while stalled.
    always_comb begin
        // ---- stage 1: capture magnitude, sign, mode and coefficients
        vld_p1_d   = adv ? in_valid                  : vld_p1_q;
        a_p1_d     = adv ? a_p0                      : a_p1_q;
        sgn_p1_d   = adv ? x_in[DATA_W-1]            : sgn_p1_q;
        sat_p1_d   = adv ? sat_p0                    : sat_p1_q;
        mode_p1_d  = adv ? mode_e'(mode_in)          : mode_p1_q;
        slope_p1_d = adv ? slope_p0                  : slope_p1_q;
        icpt_p1_d  = adv ? icpt_p0                   : icpt_p1_q;

        // ---- stage 2: rounded slope * |x|
        prod_p1    = PROD_W'(slope_p1_q) * PROD_W'(a_p1_q);
        vld_p2_d   = adv ? vld_p1_q                  : vld_p2_q;
        pr_p2_d    = adv ? round_half_up(prod_p1)    : pr_p2_q;
        sgn_p2_d   = adv ? sgn_p1_q                  : sgn_p2_q;
        sat_p2_d   = adv ? sat_p1_q                  : sat_p2_q;
        mode_p2_d  = adv ? mode_p1_q                 : mode_p2_q;
        icpt_p2_d  = adv ? icpt_p1_q                 : icpt_p2_q;

        // ---- stage 3: intercept add, clamp and symmetry fold
        sum_p2  = {{(SUM_W-DATA_W){icpt_p2_q[DATA_W-1]}}, icpt_p2_q} + {2'b00, pr_p2_q};
        ypos_p2 = sat_p2_q ? ONE : clamp_pos(sum_p2);
        if (!sgn_p2_q)
            yfin_p2 = ypos_p2;
        else if (mode_p2_q == MODE_TANH)
            yfin_p2 = -ypos_p2;
        else
            yfin_p2 = clamp_unit({ONE[DATA_W-1], ONE} - {ypos_p2[DATA_W-1], ypos_p2});
        vld_p3_d = adv ? vld_p2_q : vld_p3_q;
        y_p3_d   = adv ? yfin_p2  : y_p3_q;
    end

    // Control state and the visible result: cleared by reset, dropping in-flight samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            y_p3_q   <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            y_p3_q   <= y_p3_d;
        end
    end

    // Internal datapath registers; qualified by the valids, so no reset needed.
    always_ff @(posedge clk) begin
        a_p1_q     <= a_p1_d;
        sgn_p1_q   <= sgn_p1_d;
        sat_p1_q   <= sat_p1_d;
        mode_p1_q  <= mode_p1_d;
        slope_p1_q <= slope_p1_d;
        icpt_p1_q  <= icpt_p1_d;
        pr_p2_q    <= pr_p2_d;
        sgn_p2_q   <= sgn_p2_d;
        sat_p2_q   <= sat_p2_d;
        mode_p2_q  <= mode_p2_d;
        icpt_p2_q  <= icpt_p2_d;
    end

endmodule

// File: tb/tb_pwl_act_pipe.sv
// Directed bench for pwl_act_pipe with hand-computed expected results.
module tb_pwl_act_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic        mode_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y_out;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_slope;
    logic [15:0] cfg_icpt;

    int n_checks = 0;
    int n_fail   = 0;

    pwl_act_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .mode_in   (mode_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_slope (cfg_slope),
        .cfg_icpt  (cfg_icpt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write one table entry, one cycle long.
    task automatic cfg_write(input logic [2:0] addr, input logic [15:0] slope, input logic [15:0] icpt);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_slope = slope;
        cfg_icpt  = icpt;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Send one sample into an idle pipe and check latency and result.
    task automatic run_one(input string tag, input logic [15:0] x, input logic m, input logic [15:0] exp);
        int lat;
        in_valid = 1'b1;
        x_in     = x;
        mode_in  = m;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_lat"}, lat, 3);
        check_val(tag, y_out, exp);
    endtask

    logic [15:0] got_q[$];
    logic [15:0] xs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x_in      = '0;
        mode_in   = 1'b0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_slope = '0;
        cfg_icpt  = '0;
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_y_out", y_out, 0);
        check_val("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // out_ready low with nothing valid must not stall
        out_ready = 1'b0;
        #1 check_val("bubble_in_ready", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b1;

        // identity segment
        cfg_write(3'd0, 16'h4000, 16'h0000);
        run_one("ident_pos", 16'h0040, 1'b0, 16'h0040);
        run_one("ident_neg", 16'hFFC0, 1'b0, 16'hFFC0);

        // saturation beyond the table and at the most-negative input
        run_one("sat_pos_tanh", 16'h0400, 1'b0, 16'h0100);
        run_one("sat_min_tanh", 16'h8000, 1'b0, 16'hFF00);
        run_one("sat_min_sigm", 16'h8000, 1'b1, 16'h0000);

        // sigmoid point symmetry about 0.5
        cfg_write(3'd0, 16'h1000, 16'h0080);
        run_one("sigm_pos", 16'h0040, 1'b1, 16'h0090);
        run_one("sigm_neg", 16'hFFC0, 1'b1, 16'h0070);

        // backpressure: 6 samples, output held off for 5 cycles mid-stream
        cfg_write(3'd0, 16'h4000, 16'h0000);
        for (int i = 0; i < 6; i++) xs[i] = 16'((i + 1) * 8);
        begin
            int sent;
            sent = 0;
            for (int cyc = 0; cyc < 40 && got_q.size() < 6; cyc++) begin
                out_ready = !(cyc >= 4 && cyc < 9);
                mode_in   = 1'b0;
                if (sent < 6) begin
                    in_valid = 1'b1;
                    x_in     = xs[sent];
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (out_valid && out_ready) got_q.push_back(y_out);
                if (out_valid && !out_ready) check_val("bp_in_ready", in_ready, 0);
                if (in_valid && in_ready) sent++;
                @(negedge clk);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        check_val("bp_count", got_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_q.size()) check_val($sformatf("bp_y%0d", i), got_q[i], xs[i]);
            else check_val($sformatf("bp_y%0d_missing", i), 32'hDEAD, xs[i]);
        end
        got_q.delete();

        // config write colliding with an S1 read of the same segment
        cfg_write(3'd1, 16'h4000, 16'h0000);
        cfg_we    = 1'b1;
        cfg_addr  = 3'd1;
        cfg_slope = 16'h2000;
        cfg_icpt  = 16'h0000;
        in_valid  = 1'b1;
        x_in      = 16'h0080;
        mode_in   = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 10 && got_q.size() < 2; c++) begin
            if (out_valid) got_q.push_back(y_out);
            @(negedge clk);
        end
        check_val("coll_count", got_q.size(), 2);
        check_val("coll_old_slope", (got_q.size() > 0) ? got_q[0] : 16'hDEAD, 16'h0080);
        check_val("coll_new_slope", (got_q.size() > 1) ? got_q[1] : 16'hDEAD, 16'h0040);
        got_q.delete();
        repeat (2) @(negedge clk);

        // reset with three samples in flight
        cfg_write(3'd0, 16'h4000, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x_in     = 16'h0040;
            mode_in  = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_val("pre_rst_valid", out_valid, 1);
        check_val("pre_rst_y", y_out, 16'h0040);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_y", y_out, 0);
        check_val("mid_rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_no_stale", out_valid, 0);
        run_one("cleared_tanh", 16'h0040, 1'b0, 16'h0000);
        run_one("cleared_sigm", 16'hFFC0, 1'b1, 16'h0100);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwl_act_pipe.md
Name: pwl_act_pipe

Overview:
Parametrised piecewise-linear activation unit for fixed-point datapaths, succeeding the fixed 3-segment tanh approximator. It supports 2^SEG_LOG2 uniform segments with a runtime-loadable slope/intercept table, per-sample tanh/sigmoid mode, and a 3-stage valid/ready pipeline with full backpressure. It sits between accumulator outputs and the next layer's input buffer in the GAN inference path.

Parameters:
DATA_W, 16, width of x/y in signed Q(DATA_W-FRAC_W).FRAC_W
FRAC_W, 8, fractional bits of x/y
SEG_LOG2, 3, log2 of segment count NSEG (8)
SEG_SHIFT, 7, log2 segment width in x LSBs (0.5 at defaults, so table covers |x| in [0,4.0))
COEF_W, 16, slope width, unsigned Q(COEF_W-COEF_FRAC).COEF_FRAC
COEF_FRAC, 14, fractional bits of slope

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
x_in  in  DATA_W  signed input sample
mode_in  in  1  0 = tanh (odd symmetry), 1 = sigmoid (point symmetry about 0.5)
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts
y_out  out  DATA_W  signed result
cfg_we  in  1  table write strobe
cfg_addr  in  SEG_LOG2  segment index
cfg_slope  in  COEF_W  slope for segment
cfg_icpt  in  DATA_W  intercept for segment (y format)

Behaviour:
- Single clock domain: clk. Reset: asynchronous, active-low (rst_n), synchronous-style deassertion assumed from the reset tree.
- Reset: out_valid=0, y_out=0, all stage valids 0, all slope/intercept entries 0. in_ready=1 after reset.
- Handshake: transfer when valid&ready. Global stall: stall = out_valid & !out_ready; in_ready = !stall. When stalled, all stages hold; otherwise all advance. No bubble insertion, no sample loss, order preserved.
- Latency: 3 cycles from input accept to out_valid when no stall; throughput 1/cycle.
- S1 (register): sign s = x_in[MSB]; a = |x_in|, with x_in = most-negative mapped to 2^(DATA_W-1)-1; idx = a >> SEG_SHIFT; sat = (idx >= NSEG); read slope[idx[SEG_LOG2-1:0]], icpt[...]; register a, s, sat, mode, coefs.
- S2 (register): p = slope * a, unsigned, DATA_W+COEF_W bits; pr = (p + 2^(COEF_FRAC-1)) >> COEF_FRAC (round half up).
- S3 (register to outputs): ypos = sat ? ONE : icpt + pr, ONE = 2^FRAC_W; ypos clamped to [0, 2^(DATA_W-1)-1]. Final: s=0 -> ypos; s=1 & tanh -> -ypos; s=1 & sigmoid -> ONE - ypos, clamped to [0, ONE]. x=0 treated as positive.
- Config: cfg_we writes the entry at the clk edge, independent of stall and in_valid. A sample whose S1 table read falls in the same cycle as the write uses the old entry; samples entering S1 later use the new entry. Coefficients are latched in S1, so a later rewrite never affects an in-flight sample.
- Reset mid-operation: all in-flight samples are discarded; the table is cleared and must be reloaded.
- out_ready low with out_valid=0: no stall, so pipeline bubbles collapse.

Decomposition:
- Package pwl_act_pkg: ONE/clamp constants derived from DATA_W/FRAC_W, mode encoding (MODE_TANH=0, MODE_SIGMOID=1), and product/rounding width helpers.
- Sub-module pwl_coef_table: NSEG-entry register file with one write port and one combinational read port, async-reset clear. Pipeline stages stay in the top module.

Test Plan:
- Identity segment: slope[0]=0x4000, icpt[0]=0, tanh, x=0x0040 -> y=0x0040 after 3 cycles; x=0xFFC0 -> y=0xFFC0.
- Sigmoid symmetry: slope[0]=0x1000 (0.25), icpt[0]=0x0080, x=0x0040 -> 0x0090; x=0xFFC0 -> 0x0070.
- Saturation: x=0x0400 (4.0) tanh -> 0x0100; x=0x8000 tanh -> 0xFF00; x=0x8000 sigmoid -> 0x0000.
- Backpressure: stream 6 samples, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 while out_valid&!out_ready; all 6 results emerge in order with no duplicates.
- Config collision: write slope[1] in the same cycle a sample with idx=1 is in S1 -> that sample uses the old slope; the next idx=1 sample uses the new slope.
- Reset mid-stream: assert rst_n=0 with 3 samples in flight -> out_valid=0 and y_out=0 immediately; after release, an idx=0 sample returns y=0 (table cleared).
